mdio_ctrl: RTL and testbench
============================

# mdio_ctrl

MDIO management controller for the shared PHY control bus (`mdc`/`mdio`). It accepts single register read/write requests, serialises each as an IEEE 802.3 Clause 22 management frame, generates `mdc`, and returns read data. It sits beside `mac` in `top`; `top` owns the tri-state buffer (`mdio = mdio_oe ? mdio_o : 1'bz`, `mdio_i = mdio`).

## Interface
- `CLK_DIV`, 10: clk cycles per `mdc` half-period, minimum 2. With the 25 MHz clock this gives 1.25 MHz `mdc`.
- `clk` in 1: system clock, 25 MHz. One clock domain.
- `rst` in 1: reset, synchronous and active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller idle; a request is accepted when `req_valid && req_ready`.
- `req_write` in 1: 1 = write, 0 = read.
- `req_phy_addr` in 5: PHYAD.
- `req_reg_addr` in 5: REGAD.
- `req_wdata` in 16: write data.
- `rsp_valid` out 1: one-cycle pulse when the frame completes.
- `rsp_rdata` out 16: read data; holds until the next read completes.
- `rsp_err` out 1: read turnaround error; valid with `rsp_valid`.
- `mdc` out 1: management clock.
- `mdio_o` out 1: MDIO drive value.
- `mdio_oe` out 1: MDIO drive enable.
- `mdio_i` in 1: MDIO sampled value.

## Operation
- **Reset values:** `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `mdc`=0, `mdio_o`=1, `mdio_oe`=0.
- **Request capture:** the controller latches all `req_*` fields on acceptance. `req_valid` while busy is ignored.
- **Frame format (64 bits, MSB first):**
  - PRE: 32 × 1.
  - ST: `01`.
  - OP: `01` for write, `10` for read.
  - PHYAD: 5 bits.
  - REGAD: 5 bits.
  - TA: `10` for write; released for read.
  - DATA: 16 bits.
- **State machine:**
  - IDLE→PRE on acceptance.
  - PRE→HDR after 32 bits.
  - HDR→TA after 14 bits (ST, OP, PHYAD, REGAD).
  - TA→DATA after 2 bits.
  - DATA→IDLE after 16 bits.
- **Write frame:** `mdio_oe`=1 for all 64 bits.
- **Read frame:** `mdio_oe`=1 through HDR. `mdio_oe`=0 from the first TA bit to end of frame; `mdio_o`=1 while released.
- **Read sampling:**
  - The controller samples the second TA bit and every DATA bit from `mdio_i`.
  - DATA is shifted MSB-first into `rsp_rdata`.
  - `rsp_err` = sampled TA bit 2 == 1 (no PHY responding). `rsp_rdata` is still updated.
- **Write completion:** `rsp_rdata` is unchanged and `rsp_err`=0.
- **Reset mid-frame:** the frame is abandoned with no `rsp_valid`. All outputs take reset values on the next cycle.

## Timing
- **Bit period:** 2·`CLK_DIV` clk cycles.
  - `mdc`=0 for the first `CLK_DIV` cycles and 1 for the last `CLK_DIV`.
  - `mdio_o`/`mdio_oe` change only in the first cycle of a bit period (`mdc` falling).
  - `mdio_i` is sampled in the last low-phase cycle, immediately before `mdc` rises.
- **Acceptance at cycle T:**
  - `req_ready`=0 from T+1.
  - Bit k starts at T+1+2k·`CLK_DIV`.
- **Completion:** at T+1+128·`CLK_DIV` (T+1281 at default), `rsp_valid`=1 and `req_ready`=1 in the same cycle. A new request may be accepted in that cycle, giving back-to-back frames with no gap.
- **Idle state:** `mdc` held 0; `mdio_oe`=0.
- **Counters:**
  - Divider width is `$clog2(CLK_DIV)`.
  - Bit counter is 6 bits and counts 0..63; it does not wrap, because the FSM exits at 63.

## Structure
- **Package `mdio_pkg`:**
  - State enum: IDLE/PRE/HDR/TA/DATA.
  - Constants `MDIO_ST`=2'b01, `MDIO_OP_WRITE`=2'b01, `MDIO_OP_READ`=2'b10, `MDIO_TA_WRITE`=2'b10, `MDIO_PRE_BITS`=32, `MDIO_FRAME_BITS`=64.
- **Sub-module `mdc_gen`:** the `CLK_DIV` divider. It outputs `mdc`, a `fall_tick` (bit start), and a `sample_tick` (last low-phase cycle), and runs only while busy.
- **FSM and 32-bit shift register** (ST..DATA) stay in `mdio_ctrl`.

## Test plan
- **Reset:** assert `rst` for 2 cycles → all outputs equal their reset values; `mdc` does not toggle for 2000 cycles.
- **Write:** PHY 1, reg 0, data 16'h1140 → bits captured at `mdc` rising edges are 32×`1` then `01 01 00001 00000 10 0001000101000000`; `rsp_valid` exactly 1281 cycles after acceptance; `rsp_err`=0.
- **Read with PHY model:** PHY 0, reg 2; the model drives TA `0` and data 16'h0141 → `mdio_oe`=0 from TA bit 1; `rsp_rdata`=16'h0141; `rsp_err`=0.
- **Read, no PHY:** `mdio_i` tied to 1 → `rsp_rdata`=16'hFFFF; `rsp_err`=1.
- **Back-to-back and busy requests:** `req_valid` held with a write followed by a read → the read is accepted in the `rsp_valid` cycle of the write. A request pulsed mid-frame is dropped.
- **Reset during read DATA bit 5:** no `rsp_valid`; reset values appear the next cycle. A subsequent write completes correctly.

Source files
------------

// File: rtl/mdio_pkg.sv
// Shared types and frame constants for the Clause 22 MDIO management controller.
package mdio_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    HDR,
    TA,
    DATA
  } mdio_state_e;

  localparam logic [1:0] MDIO_ST       = 2'b01;
  localparam logic [1:0] MDIO_OP_WRITE = 2'b01;
  localparam logic [1:0] MDIO_OP_READ  = 2'b10;
  localparam logic [1:0] MDIO_TA_WRITE = 2'b10;

  localparam int MDIO_PRE_BITS   = 32;
  localparam int MDIO_FRAME_BITS = 64;

  // Frame bit indices at which each field begins, sized to the 6-bit bit counter.
  localparam logic [5:0] MDIO_BIT_HDR  = 6'(MDIO_PRE_BITS);
  localparam logic [5:0] MDIO_BIT_TA   = 6'(MDIO_PRE_BITS + 14);
  localparam logic [5:0] MDIO_BIT_DATA = 6'(MDIO_PRE_BITS + 16);
  localparam logic [5:0] MDIO_BIT_LAST = 6'(MDIO_FRAME_BITS - 1);

endpackage

// File: rtl/mdc_gen.sv
// MDC divider: CLK_DIV clk cycles low then CLK_DIV high per bit, free only while busy.
// Ticks mark bit start, the last low-phase cycle (read sample) and the last cycle of the bit.
module mdc_gen #(
  parameter int CLK_DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic busy,
  output logic mdc,
  output logic fall_tick,
  output logic sample_tick,
  output logic end_tick
);

  localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [W-1:0] DIV_LAST = W'(CLK_DIV - 1);

  logic [W-1:0] div_cnt;

  // Held at the start of a low phase whenever idle, so every frame begins on a clean bit boundary.
  always_ff @(posedge clk) begin
    if (rst || !busy) begin
      div_cnt <= '0;
      mdc     <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      mdc     <= ~mdc;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign fall_tick   = busy && !mdc && (div_cnt == '0);
  assign sample_tick = busy && !mdc && (div_cnt == DIV_LAST);
  assign end_tick    = busy &&  mdc && (div_cnt == DIV_LAST);

endmodule

// File: rtl/mdio_ctrl.sv
// Clause 22 MDIO controller: one read/write request per 64-bit frame, returns read data.
// Outputs are registered and only change on bit boundaries (mdc falling).
module mdio_ctrl
  import mdio_pkg::*;
#(
  parameter int CLK_DIV = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [4:0]  req_phy_addr,
  input  logic [4:0]  req_reg_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        mdio_i
);

  mdio_state_e state_q, state_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic [31:0] shreg_q, shreg_d;
  logic        wr_q, wr_d;
  logic [15:0] rd_shift_q, rd_shift_d;
  logic        ta_err_q, ta_err_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [15:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic        mdio_o_q, mdio_o_d;
  logic        mdio_oe_q, mdio_oe_d;

  logic        busy;
  logic        fall_tick;
  logic        sample_tick;
  logic        end_tick;
  logic [5:0]  nxt_bit;
  logic        nxt_oe;

  assign busy = (state_q != IDLE);

  mdc_gen #(.CLK_DIV(CLK_DIV)) u_mdc_gen (
    .clk         (clk),
    .rst         (rst),
    .busy        (busy),
    .mdc         (mdc),
    .fall_tick   (fall_tick),
    .sample_tick (sample_tick),
    .end_tick    (end_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      wr_q        <= 1'b0;
      rd_shift_q  <= '0;
      ta_err_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      mdio_o_q    <= 1'b1;
      mdio_oe_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      wr_q        <= wr_d;
      rd_shift_q  <= rd_shift_d;
      ta_err_q    <= ta_err_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      mdio_o_q    <= mdio_o_d;
      mdio_oe_q   <= mdio_oe_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    wr_d        = wr_q;
    rd_shift_d  = rd_shift_q;
    ta_err_d    = ta_err_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    mdio_o_d    = mdio_o_q;
    mdio_oe_d   = mdio_oe_q;
    nxt_bit     = bit_cnt_q + 6'd1;
    nxt_oe      = wr_q || (nxt_bit < MDIO_BIT_TA);

    if (state_q == IDLE) begin
      if (req_valid) begin
        state_d   = PRE;
        bit_cnt_d = '0;
        wr_d      = req_write;
        // Read frames carry ones in TA/DATA so the released line idles high.
        shreg_d   = {MDIO_ST,
                     req_write ? MDIO_OP_WRITE : MDIO_OP_READ,
                     req_phy_addr,
                     req_reg_addr,
                     req_write ? MDIO_TA_WRITE : 2'b11,
                     req_write ? req_wdata : 16'hFFFF};
        mdio_o_d  = 1'b1;
        mdio_oe_d = 1'b1;
      end
    end else begin
      // shreg_q[31] always holds the bit that follows the one on the wire.
      if (fall_tick && (bit_cnt_q >= MDIO_BIT_HDR)) begin
        shreg_d = {shreg_q[30:0], 1'b1};
      end

      if (sample_tick && !wr_q) begin
        if (state_q == TA) ta_err_d = mdio_i;
        if (state_q == DATA) rd_shift_d = {rd_shift_q[14:0], mdio_i};
      end

      if (end_tick) begin
        if (bit_cnt_q == MDIO_BIT_LAST) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          mdio_o_d    = 1'b1;
          mdio_oe_d   = 1'b0;
          if (wr_q) begin
            rsp_err_d = 1'b0;
          end else begin
            rsp_rdata_d = rd_shift_q;
            rsp_err_d   = ta_err_q;
          end
        end else begin
          bit_cnt_d = nxt_bit;
          mdio_oe_d = nxt_oe;
          mdio_o_d  = !nxt_oe || (nxt_bit < MDIO_BIT_HDR) || shreg_q[31];
          unique case (state_q)
            PRE:     if (nxt_bit == MDIO_BIT_HDR)  state_d = HDR;
            HDR:     if (nxt_bit == MDIO_BIT_TA)   state_d = TA;
            TA:      if (nxt_bit == MDIO_BIT_DATA) state_d = DATA;
            default: state_d = state_q;
          endcase
        end
      end
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mdio_o    = mdio_o_q;
  assign mdio_oe   = mdio_oe_q;

endmodule

// File: tb/tb_mdio_ctrl.sv
// Directed bench for mdio_ctrl with a scoreboard of expected responses and a simple PHY model.
module tb_mdio_ctrl;

  localparam int CD        = 10;
  localparam int BITCYC    = 2 * CD;
  localparam int LATENCY   = 128 * CD + 1;
  localparam int BOUND     = 3000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [4:0]  req_phy_addr;
  logic [4:0]  req_reg_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic        mdc;
  logic        mdio_o;
  logic        mdio_oe;
  logic        mdio_i;

  mdio_ctrl #(.CLK_DIV(CD)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_phy_addr (req_phy_addr),
    .req_reg_addr (req_reg_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mdc          (mdc),
    .mdio_o       (mdio_o),
    .mdio_oe      (mdio_oe),
    .mdio_i       (mdio_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e_mon;
  int          acc_hist[$];
  int          n_checks = 0;
  int          n_err    = 0;
  int          cyc      = 0;
  int          acc_cyc  = 0;
  int          acc_n    = 0;
  int          rsp_n    = 0;
  int          mdc_toggles = 0;
  int          k_bit;
  int          cap_n = 0;
  logic [63:0] cap_o  = '0;
  logic [63:0] cap_oe = '0;
  logic        mdc_q  = 1'b0;
  logic        cur_wr = 1'b1;
  logic        phy_en = 1'b0;
  logic [15:0] phy_data = '0;
  logic [15:0] model_rdata = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: bit capture at mdc rise, scoreboard push/pop, PHY model drive.
  always @(negedge clk) begin
    if (mdc !== mdc_q) mdc_toggles++;
    if (mdc && !mdc_q && cap_n < 64) begin
      cap_o  = {cap_o[62:0], mdio_o};
      cap_oe = {cap_oe[62:0], mdio_oe};
      cap_n++;
    end
    mdc_q = mdc;

    if (rst) begin
      exp_q.delete();
      model_rdata = '0;
    end else begin
      if (rsp_valid) begin
        rsp_n++;
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", 64'd1, 64'd0);
        end else begin
          e_mon = exp_q.pop_front();
          check("rsp_rdata", 64'(rsp_rdata), 64'(e_mon.rdata));
          check("rsp_err", 64'(rsp_err), 64'(e_mon.err));
          check("rsp_cycle", 64'(cyc), 64'(e_mon.due));
        end
      end
      if (req_valid && req_ready) begin
        acc_cyc = cyc;
        acc_n++;
        acc_hist.push_back(cyc);
        cur_wr = req_write;
        cap_n  = 0;
        cap_o  = '0;
        cap_oe = '0;
        if (req_write) begin
          e_mon.rdata = model_rdata;
          e_mon.err   = 1'b0;
        end else begin
          e_mon.rdata = phy_en ? phy_data : 16'hFFFF;
          e_mon.err   = !phy_en;
          model_rdata = e_mon.rdata;
        end
        e_mon.due = cyc + LATENCY;
        exp_q.push_back(e_mon);
      end
    end

    k_bit = (cyc - acc_cyc - 1) / BITCYC;
    if (phy_en && !cur_wr && !rst && cyc > acc_cyc && k_bit >= 47 && k_bit <= 63)
      mdio_i = (k_bit == 47) ? 1'b0 : phy_data[63 - k_bit];
    else
      mdio_i = 1'b1;
  end

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_req_ready"}, 64'(req_ready), 64'd1);
    check({pfx, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    check({pfx, "_rsp_rdata"}, 64'(rsp_rdata), 64'd0);
    check({pfx, "_rsp_err"},   64'(rsp_err),   64'd0);
    check({pfx, "_mdc"},       64'(mdc),       64'd0);
    check({pfx, "_mdio_o"},    64'(mdio_o),    64'd1);
    check({pfx, "_mdio_oe"},   64'(mdio_oe),   64'd0);
  endtask

  task automatic send(input logic w, input logic [4:0] p, input logic [4:0] r, input logic [15:0] d);
    int n = 0;
    @(posedge clk); #1;
    req_write = w; req_phy_addr = p; req_reg_addr = r; req_wdata = d; req_valid = 1'b1;
    @(negedge clk);
    while (!req_ready && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    if (n >= BOUND) check("send_timeout", 64'd1, 64'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin : stim
    int t0;
    int a0;
    int r0;
    int n;
    int target;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0;
    req_phy_addr = '0; req_reg_addr = '0; req_wdata = '0; mdio_i = 1'b1;

    // Reset and idle behaviour
    @(negedge clk);
    check_reset_vals("in_reset");
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_reset_vals("after_reset");
    t0 = mdc_toggles;
    repeat (2000) @(negedge clk);
    check("idle_mdc_toggles", 64'(mdc_toggles - t0), 64'd0);
    check("idle_mdio_oe", 64'(mdio_oe), 64'd0);

    // Write PHY 1 reg 0 = 0x1140
    send(1'b1, 5'd1, 5'd0, 16'h1140);
    wait_done("write_done");
    check("write_bits_n", 64'(cap_n), 64'd64);
    check("write_bits", cap_o, {32'hFFFF_FFFF, 2'b01, 2'b01, 5'd1, 5'd0, 2'b10, 16'h1140});
    check("write_oe", cap_oe, {64{1'b1}});
    check("write_idle_oe", 64'(mdio_oe), 64'd0);

    // Read PHY 0 reg 2 with responding PHY
    phy_en = 1'b1; phy_data = 16'h0141;
    send(1'b0, 5'd0, 5'd2, 16'h0000);
    wait_done("read_done");
    check("read_bits", cap_o, {32'hFFFF_FFFF, 2'b01, 2'b10, 5'd0, 5'd2, 18'h3FFFF});
    check("read_oe", cap_oe, {{46{1'b1}}, {18{1'b0}}});

    // Read with no PHY on the bus
    phy_en = 1'b0;
    send(1'b0, 5'd5, 5'd3, 16'h0000);
    wait_done("nophy_done");

    // Back-to-back write then read, plus a request pulsed mid-frame
    phy_en = 1'b1; phy_data = 16'hBEEF;
    a0 = acc_n;
    @(posedge clk); #1;
    req_write = 1'b1; req_phy_addr = 5'd3; req_reg_addr = 5'd4; req_wdata = 16'hA5A5; req_valid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    req_write = 1'b0; req_reg_addr = 5'd5; req_wdata = 16'h0000;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    if (n >= BOUND) check("b2b_timeout", 64'd1, 64'd0);
    @(posedge clk); #1 req_valid = 1'b0;
    check("b2b_accepts", 64'(acc_n - a0), 64'd2);
    check("b2b_gap", 64'(acc_hist[acc_hist.size()-1] - acc_hist[acc_hist.size()-2]), 64'(LATENCY));
    repeat (300) @(posedge clk);
    #1 req_valid = 1'b1; req_write = 1'b1; req_wdata = 16'h5555;
    @(posedge clk); #1 req_valid = 1'b0;
    wait_done("b2b_done");
    check("busy_req_dropped", 64'(acc_n - a0), 64'd2);

    // Reset during DATA bit 5 of a read
    phy_data = 16'h1234;
    send(1'b0, 5'd1, 5'd1, 16'h0000);
    target = acc_cyc + 1 + (48 + 5) * BITCYC + 5;
    n = 0;
    while (cyc < target && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_vals("mid_reset");
    @(posedge clk); #1 rst = 1'b0;
    phy_en = 1'b0;
    r0 = rsp_n;
    repeat (1500) @(negedge clk);
    check("abandoned_no_rsp", 64'(rsp_n - r0), 64'd0);

    send(1'b1, 5'd2, 5'd9, 16'h0F0F);
    wait_done("post_reset_write_done");
    check("post_reset_write_bits", cap_o, {32'hFFFF_FFFF, 2'b01, 2'b01, 5'd2, 5'd9, 2'b10, 16'h0F0F});
    check("total_rsp", 64'(rsp_n), 64'd6);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
